ts_null_stuffer: RTL and testbench

- Output stage directly downstream of the T2-MI-over-TS packetizer.
- Captures the packetizer's bursty, gapped 188-byte TS packets (byte strobe plus sync flag) into a small multi-packet buffer.
- Replays them at a constant byte rate set by an external tick.
- Inserts null packets (PID 0x1FFF) whenever no complete packet is buffered, so the downstream modulator/ASI interface always sees a continuous TS.

---
 rtl/ts_null_stuffer.sv | 112 +++++++++++
 tb/tb_ts_null_stuffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_null_stuffer.sv
// ts_null_stuffer: buffers gapped 188-byte TS packets and replays them at the BYTE_TICK rate.
// Define T2MI_NULL_STUFF_EN to emit null packets (PID 0x1FFF) whenever no packet is buffered.
module ts_null_stuffer #(
  parameter int DEPTH_PKTS = 4,
  parameter int PKT_LEN = 188
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       ENA_IN,
  input  logic       PSYNC_IN,
  input  logic       BYTE_TICK,
  output logic       READY,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PSYNC_OUT,
  output logic       DROP,
  output logic [3:0] FILL
);
  localparam int MEM = DEPTH_PKTS * PKT_LEN;
  localparam int AW = $clog2(MEM);
  localparam int CW = 5;
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);
  localparam logic [AW-1:0] STEP = AW'(PKT_LEN);
  localparam logic [AW-1:0] TOP = AW'(MEM - PKT_LEN);
  localparam logic [CW-1:0] DEPTH = CW'(DEPTH_PKTS);
  typedef enum logic {IDLE, CAPTURE} wstate_t;
  wstate_t wstate, wstate_n;
  logic [7:0] mem [MEM];
  logic [7:0] widx, widx_n, ridx, nullb, nb1, rd_q;
  logic [AW-1:0] wbase, rbase, waddr, raddr;
  logic [CW-1:0] cnt;
  logic we, commit, drop_n, adv, use_buf, rls, src, v1, s1, p1;
  assign FILL = cnt[3:0];
  // Slot bases advance by one packet length so no multiplier is needed.
  assign raddr = rbase + AW'(ridx);
  assign use_buf = (ridx == '0) ? (cnt != '0) : src;
`ifdef T2MI_NULL_STUFF_EN
  assign adv = BYTE_TICK;
`else
  assign adv = BYTE_TICK && (ridx != '0 || cnt != '0);
`endif
  assign rls = adv && use_buf && ridx == LAST;
  assign nullb = (ridx == 8'd0) ? 8'h47 : (ridx == 8'd1) ? 8'h1F : (ridx == 8'd3) ? 8'h10 : 8'hFF;
  always_comb begin
    wstate_n = wstate;
    widx_n = widx;
    we = 1'b0;
    waddr = wbase + AW'(widx);
    commit = 1'b0;
    drop_n = 1'b0;
    if (ENA_IN) begin
      if (PSYNC_IN && (wstate == CAPTURE || cnt < DEPTH)) begin
        drop_n = wstate == CAPTURE;
        we = 1'b1;
        waddr = wbase;
        widx_n = 8'd1;
        wstate_n = CAPTURE;
      end else if (PSYNC_IN) begin
        drop_n = 1'b1;
      end else if (wstate == CAPTURE) begin
        we = 1'b1;
        commit = widx == LAST;
        widx_n = commit ? '0 : widx + 1'b1;
        wstate_n = commit ? IDLE : CAPTURE;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= DATA_IN;
    if (adv) rd_q <= mem[raddr];
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wstate <= IDLE;
      widx <= '0;
      wbase <= '0;
      rbase <= '0;
      ridx <= '0;
      cnt <= '0;
      src <= 1'b0;
      v1 <= 1'b0;
      s1 <= 1'b0;
      p1 <= 1'b0;
      nb1 <= '0;
      READY <= 1'b1;
      DROP <= 1'b0;
      ENA_OUT <= 1'b0;
      PSYNC_OUT <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      wstate <= wstate_n;
      widx <= widx_n;
      if (commit) wbase <= (wbase == TOP) ? '0 : wbase + STEP;
      if (rls) rbase <= (rbase == TOP) ? '0 : rbase + STEP;
      cnt <= cnt + CW'(commit) - CW'(rls);
      READY <= (cnt + CW'(wstate == CAPTURE)) < DEPTH;
      DROP <= drop_n;
      if (adv) begin
        ridx <= (ridx == LAST) ? '0 : ridx + 1'b1;
        src <= use_buf;
      end
      v1 <= adv;
      s1 <= use_buf;
      p1 <= ridx == '0;
      nb1 <= nullb;
      ENA_OUT <= v1;
      PSYNC_OUT <= v1 && p1;
      if (v1) DATA_OUT <= s1 ? rd_q : nb1;
    end
  end
endmodule

// File: tb/tb_ts_null_stuffer.sv
// tb_ts_null_stuffer: scoreboard bench for ts_null_stuffer, default build or T2MI_NULL_STUFF_EN.
module tb_ts_null_stuffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data_in = '0;
  logic ena_in = 1'b0;
  logic psync_in = 1'b0;
  logic byte_tick = 1'b0;
  logic ready, ena_out, psync_out, drop;
  logic [7:0] data_out;
  logic [3:0] fill;
  int n_chk = 0;
  int n_fail = 0;
  int out_bytes = 0;
  int nulls = 0;
  int drops = 0;
  int ticks = 0;
  int tick_period = 0;
  int phase = 0;
  int mo_idx = 0;
  int b0, n0;
  logic tick_force = 1'b0;
  logic [1:0] td = '0;
  logic [7:0] exp_q [$];
  logic [7:0] pkt [188];
  logic is_null;
  ts_null_stuffer dut (
    .CLK(clk), .RST(rst), .DATA_IN(data_in), .ENA_IN(ena_in), .PSYNC_IN(psync_in),
    .BYTE_TICK(byte_tick), .READY(ready), .DATA_OUT(data_out), .ENA_OUT(ena_out),
    .PSYNC_OUT(psync_out), .DROP(drop), .FILL(fill)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] pb(input int tag, input int i);
    logic [7:0] t = 8'(tag);
    return (i == 0) ? 8'h47 : (i == 1) ? 8'h40 : (i == 2) ? 8'h64 :
           (i == 3) ? (8'h10 | (t & 8'h0F)) : 8'(i - 4 + tag * 7);
  endfunction
  function automatic logic [7:0] null_byte(input int i);
    return (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 2) ? 8'hFF : (i == 3) ? 8'h10 : 8'hFF;
  endfunction
  task automatic cyc(input logic e, input logic p, input logic [7:0] d);
    ena_in = e;
    psync_in = p;
    data_in = d;
    byte_tick = tick_force || (tick_period != 0 && phase == 0);
    if (byte_tick) ticks++;
    phase = (tick_period == 0) ? 0 : (phase + 1) % tick_period;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask
  task automatic send(input int tag, input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      repeat ($urandom_range(gap, 0)) cyc(1'b0, 1'b0, 8'($urandom));
      cyc(1'b1, i == 0, pb(tag, i));
    end
  endtask
  task automatic push(input int tag);
    for (int i = 0; i < 188; i++) exp_q.push_back(pb(tag, i));
  endtask
  task automatic wait_fill(input int target, input int budget);
    for (int i = 0; i < budget && int'(fill) != target; i++) idle(1);
    chk("fill_wait", 32'(fill), 32'(target));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(data_out), 0);
    chk({tag, "_ena"}, 32'(ena_out), 0);
    chk({tag, "_psync"}, 32'(psync_out), 0);
    chk({tag, "_drop"}, 32'(drop), 0);
    chk({tag, "_fill"}, 32'(fill), 0);
    chk({tag, "_ready"}, 32'(ready), 1);
  endtask
  // Output monitor: checks tick latency and PSYNC, assembles packets and scores them.
  always @(negedge clk) begin
    if (!rst) begin
      mo_idx = 0;
      td = '0;
    end else begin
`ifdef T2MI_NULL_STUFF_EN
      chk("ena_latency", 32'(ena_out), 32'(td[1]));
`else
      if (ena_out) chk("ena_latency", 32'(td[1]), 1);
`endif
      td = {td[0], byte_tick};
      if (drop) drops++;
      if (!ena_out) chk("psync_idle", 32'(psync_out), 0);
      else begin
        chk("psync_pos", 32'(psync_out), 32'(mo_idx == 0));
        pkt[mo_idx] = data_out;
        out_bytes++;
        if (mo_idx == 187) begin
          mo_idx = 0;
          is_null = 1'b0;
`ifdef T2MI_NULL_STUFF_EN
          is_null = pkt[1] == 8'h1F;
`endif
          if (is_null) begin
            nulls++;
            for (int i = 0; i < 188; i++) chk("null_byte", 32'(pkt[i]), 32'(null_byte(i)));
          end else begin
            chk("pkt_expected", 32'(exp_q.size() >= 188), 1);
            if (exp_q.size() >= 188)
              for (int i = 0; i < 188; i++) chk("pkt_byte", 32'(pkt[i]), 32'(exp_q.pop_front()));
          end
        end else mo_idx++;
      end
    end
  end
  initial begin
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(2);
    // Empty buffer, 376 ticks.
    tick_period = 1;
    idle(376);
    tick_period = 0;
    idle(6);
`ifdef T2MI_NULL_STUFF_EN
    chk("t1_bytes", 32'(out_bytes), 376);
    chk("t1_nulls", 32'(nulls), 2);
`else
    chk("t1_bytes", 32'(out_bytes), 0);
`endif
    chk("t1_drops", 32'(drops), 0);
    // One gapped packet while ticking every 3 CLK.
    tick_period = 3;
    push(0);
    send(0, 0, 187, 3);
    chk("t2_fill_pre", 32'(fill), 0);
    send(0, 187, 188, 3);
    idle(2);
    chk("t2_fill_commit", 32'(fill), 1);
    wait_fill(0, 2000);
    idle(10);
    chk("t2_drained", 32'(exp_q.size()), 0);
    tick_period = 0;
    idle(2);
    // Fill all four slots, then overflow with a fifth.
    for (int t = 1; t <= 3; t++) begin
      push(t);
      send(t, 0, 188, 1);
    end
    idle(2);
    chk("t3_fill3", 32'(fill), 3);
    chk("t3_ready3", 32'(ready), 1);
    push(4);
    send(4, 0, 1, 1);
    idle(2);
    chk("t3_ready_after_4th_sync", 32'(ready), 0);
    send(4, 1, 188, 1);
    idle(2);
    chk("t3_fill4", 32'(fill), 4);
    send(5, 0, 188, 1);
    idle(2);
    chk("t3_drop", 32'(drops), 1);
    chk("t3_fill_after_drop", 32'(fill), 4);
    chk("t3_ready_full", 32'(ready), 0);
    tick_period = 1;
    wait_fill(0, 2000);
    idle(10);
    chk("t3_drained", 32'(exp_q.size()), 0);
    chk("t3_ready_empty", 32'(ready), 1);
    tick_period = 0;
    idle(2);
    // Resync: a PSYNC at byte 100 restarts the slot.
    send(7, 0, 100, 1);
    push(8);
    send(8, 0, 188, 1);
    idle(2);
    chk("t4_drop", 32'(drops), 2);
    chk("t4_fill", 32'(fill), 1);
    tick_period = 1;
    wait_fill(0, 2000);
    idle(10);
    chk("t4_drained", 32'(exp_q.size()), 0);
    tick_period = 0;
    idle(2);
    // Commit into slot 0 on the same CLK as slot 2 is released.
    push(9);
    send(9, 0, 188, 0);
    push(10);
    send(10, 0, 188, 0);
    idle(2);
    chk("t5_fill_pre", 32'(fill), 2);
`ifdef T2MI_NULL_STUFF_EN
    tick_force = 1'b1;
    idle((188 - ticks % 188) % 188);
    tick_force = 1'b0;
`endif
    push(11);
    tick_force = 1'b1;
    for (int i = 0; i < 188; i++) cyc(1'b1, i == 0, pb(11, i));
    tick_force = 1'b0;
    idle(2);
    chk("t5_fill_same", 32'(fill), 2);
    tick_period = 1;
    wait_fill(0, 2000);
    idle(10);
    chk("t5_drained", 32'(exp_q.size()), 0);
    // Asynchronous reset in the middle of a buffered packet.
    tick_period = 0;
    push(12);
    send(12, 0, 188, 0);
    push(13);
    send(13, 0, 188, 0);
    tick_period = 1;
    idle(50);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    tick_period = 0;
    idle(3);
    check_reset_outputs("midrst_hold");
    ticks = 0;
    rst = 1'b1;
    b0 = out_bytes;
    n0 = nulls;
`ifdef T2MI_NULL_STUFF_EN
    tick_period = 1;
    idle(188);
    tick_period = 0;
    idle(10);
    chk("t6_null_bytes", 32'(out_bytes - b0), 188);
    chk("t6_null_pkt", 32'(nulls - n0), 1);
`else
    tick_period = 1;
    idle(200);
    chk("t6_no_output", 32'(out_bytes - b0), 0);
`endif
    push(14);
    send(14, 0, 188, 2);
    tick_period = 1;
    wait_fill(0, 2000);
    idle(10);
    tick_period = 0;
    idle(2);
    chk("t6_drained", 32'(exp_q.size()), 0);
    chk("final_drops", 32'(drops), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
